// File: rtl/mips_run_ctrl_if.sv
// Board/core-facing signal bundle for mips_run_ctrl.
// master = board inputs and core side, slave = the run controller.
interface mips_run_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic             step;
  logic             run_mode;
  logic             halt_req;
  logic             resume;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  bp_addr;
  logic             bp_valid;
  logic             cpu_en;
  logic             cpu_rst_n;
  logic [2:0]       state;
  logic             halted;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output step, run_mode, halt_req, resume, pc, bp_addr, bp_valid,
    input  cpu_en, cpu_rst_n, state, halted, instr_count
  );

  modport slave (
    input  step, run_mode, halt_req, resume, pc, bp_addr, bp_valid,
    output cpu_en, cpu_rst_n, state, halted, instr_count
  );
endinterface

// File: rtl/mips_run_ctrl.sv
// Run/step sequencer: core advance enable, stretched core reset, advanced-cycle count.
// Inputs step/run_mode see 2-cycle sync latency; optional breakpoint halt via `define BREAKPOINT_EN.
module mips_run_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int RESET_HOLD_CYCLES = 4,
  parameter int PC_W              = 32,
  parameter int CNT_W             = 32
) (
  input  logic           clk,
  input  logic           rst,
  mips_run_ctrl_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_STEP  = 3'd3,
    S_HALT  = 3'd4
  } run_state_t;

  logic             step_m, step_s;
  logic             run_m, run_s;
  logic             deb_lvl;
  logic [DW-1:0]    deb_cnt;
  logic             step_pulse;
  run_state_t       cur, nxt;
  logic [HW-1:0]    hold_cnt;
  logic             hold_done;
  logic             cpu_en_r, cpu_rst_n_r, halted_r;
  logic [CNT_W-1:0] cnt;
  logic             bp_hit;
  logic             halt_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_m <= 1'b0;
      step_s <= 1'b0;
      run_m  <= 1'b0;
      run_s  <= 1'b0;
    end else begin
      step_m <= bus.step;
      step_s <= step_m;
      run_m  <= bus.run_mode;
      run_s  <= run_m;
    end
  end

  // Any cycle where step_s agrees with the debounced level restarts the stability count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_lvl    <= 1'b0;
      deb_cnt    <= '0;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (step_s == deb_lvl) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_lvl    <= step_s;
        deb_cnt    <= '0;
        step_pulse <= step_s;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

`ifdef BREAKPOINT_EN
  logic last_hit;
  logic bp_match;

  assign bp_match = bus.bp_valid && (bus.pc == bus.bp_addr);
  assign bp_hit   = cpu_en_r && bp_match && !last_hit;

  // Keeps a resumed core from re-halting on the same PC until it moves on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_hit <= 1'b0;
    end else if (bus.pc != bus.bp_addr) begin
      last_hit <= 1'b0;
    end else if (bp_hit) begin
      last_hit <= 1'b1;
    end
  end
`else
  logic [PC_W:0] unused_bp;

  assign unused_bp = {bus.pc ^ bus.bp_addr, bus.bp_valid};
  assign bp_hit    = 1'b0;
`endif

  assign halt_hit  = (bus.halt_req && cpu_en_r) || bp_hit;
  assign hold_done = (hold_cnt == HOLD_LAST);

  always_comb begin
    nxt = cur;
    case (cur)
      S_HOLD:  if (hold_done) nxt = run_s ? S_RUN : S_PAUSE;
      S_RUN: begin
        if (halt_hit)    nxt = S_HALT;
        else if (!run_s) nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (run_s)           nxt = S_RUN;
        else if (step_pulse) nxt = S_STEP;
      end
      S_STEP: begin
        if (halt_hit)   nxt = S_HALT;
        else if (run_s) nxt = S_RUN;
        else            nxt = S_PAUSE;
      end
      S_HALT:  if (bus.resume) nxt = run_s ? S_RUN : S_PAUSE;
      default: nxt = S_HOLD;
    endcase
  end

  // Outputs are registered from the next state so they change only with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur         <= S_HOLD;
      hold_cnt    <= '0;
      cpu_en_r    <= 1'b0;
      cpu_rst_n_r <= 1'b0;
      halted_r    <= 1'b0;
      cnt         <= '0;
    end else begin
      cur         <= nxt;
      if ((cur == S_HOLD) && !hold_done) hold_cnt <= hold_cnt + HW'(1);
      cpu_en_r    <= (nxt == S_RUN) || (nxt == S_STEP);
      cpu_rst_n_r <= (nxt != S_HOLD);
      halted_r    <= (nxt == S_HALT);
      if (cpu_en_r) cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.cpu_en      = cpu_en_r;
  assign bus.cpu_rst_n   = cpu_rst_n_r;
  assign bus.halted      = halted_r;
  assign bus.state       = cur;
  assign bus.instr_count = cnt;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed + randomized bench for mips_run_ctrl against a cycle-level reference model.
module tb_mips_run_ctrl;
  localparam int DEB     = 4;
  localparam int HOLDN   = 4;
  localparam int S_HOLD  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_STEP  = 3;
  localparam int S_HALT  = 4;
  localparam logic [31:0] BASE = 32'h0040_0000;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  mips_run_ctrl_if #(.PC_W(32), .CNT_W(32)) bus();

  mips_run_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .RESET_HOLD_CYCLES(HOLDN),
    .PC_W(32),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: values visible after the most recent clock edge.
  int          m_state, m_hold, m_dlen;
  bit          m_deb, m_pulse, m_run_s, m_step_s, m_last_hit;
  logic [31:0] m_count;
  bit          q_step[$];
  bit          q_run[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_HOLD; m_hold = 0; m_dlen = 0;
    m_deb = 0; m_pulse = 0; m_run_s = 0; m_step_s = 0; m_last_hit = 0;
    m_count = '0;
    q_step.delete();
    q_run.delete();
  endtask

  task automatic check_all();
    check("state",     {29'd0, bus.state}, m_state);
    check("cpu_en",    {31'd0, bus.cpu_en}, {31'd0, (m_state == S_RUN) || (m_state == S_STEP)});
    check("cpu_rst_n", {31'd0, bus.cpu_rst_n}, {31'd0, m_state != S_HOLD});
    check("halted",    {31'd0, bus.halted}, {31'd0, m_state == S_HALT});
    check("count",     bus.instr_count, m_count);
  endtask

  // One clock: predict from current inputs, advance the edge, compare, let the mini-core move pc.
  task automatic tick();
    bit en, bp, halt, n_deb, n_pulse, n_last, n_step_s, n_run_s;
    int ns, n_dlen;
    if (!rst) begin
      model_reset();
      @(posedge clk);
      #1;
      check_all();
      return;
    end
    en = (m_state == S_RUN) || (m_state == S_STEP);
    bp = 1'b0;
`ifdef BREAKPOINT_EN
    bp = en && bus.bp_valid && (bus.pc == bus.bp_addr) && !m_last_hit;
`endif
    halt = (bus.halt_req && en) || bp;
    ns = m_state;
    case (m_state)
      S_HOLD:  if (m_hold + 1 >= HOLDN) ns = m_run_s ? S_RUN : S_PAUSE;
      S_RUN:   ns = halt ? S_HALT : (!m_run_s ? S_PAUSE : S_RUN);
      S_PAUSE: ns = m_run_s ? S_RUN : (m_pulse ? S_STEP : S_PAUSE);
      S_STEP:  ns = halt ? S_HALT : (m_run_s ? S_RUN : S_PAUSE);
      S_HALT:  if (bus.resume) ns = m_run_s ? S_RUN : S_PAUSE;
      default: ns = S_HOLD;
    endcase
    n_deb = m_deb; n_pulse = 0; n_dlen = 0;
    if (m_step_s != m_deb) begin
      n_dlen = m_dlen + 1;
      if (n_dlen == DEB) begin
        n_deb = m_step_s; n_dlen = 0; n_pulse = m_step_s;
      end
    end
    n_last = m_last_hit;
    if (bus.pc != bus.bp_addr) n_last = 0;
    else if (bp) n_last = 1;
    q_step.push_back(bus.step);
    q_run.push_back(bus.run_mode);
    n_step_s = (q_step.size() >= 2) ? q_step[q_step.size()-2] : 1'b0;
    n_run_s  = (q_run.size()  >= 2) ? q_run[q_run.size()-2]   : 1'b0;
    if (q_step.size() > 2) void'(q_step.pop_front());
    if (q_run.size() > 2) void'(q_run.pop_front());
    @(posedge clk);
    if (m_state == S_HOLD) m_hold = m_hold + 1;
    if (en) m_count = m_count + 32'd1;
    m_state = ns; m_deb = n_deb; m_pulse = n_pulse; m_dlen = n_dlen;
    m_last_hit = n_last; m_step_s = n_step_s; m_run_s = n_run_s;
    #1;
    check_all();
    if (en) bus.pc = bus.pc + 32'd4;
  endtask

  initial begin
    int          hold_left;
    int          en_cyc;
    int          found;
    int          hit_at;
    logic [31:0] snap;

    rst = 1'b1;
    bus.step = 0; bus.run_mode = 1; bus.halt_req = 0; bus.resume = 0;
    bus.pc = '0; bus.bp_addr = '0; bus.bp_valid = 0;
    model_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_state",     {29'd0, bus.state}, 32'd0);
    check("rst_cpu_en",    {31'd0, bus.cpu_en}, 32'd0);
    check("rst_cpu_rst_n", {31'd0, bus.cpu_rst_n}, 32'd0);
    check("rst_count",     bus.instr_count, 32'd0);
    tick(); tick();

    // Reset release with run_mode=1
    rst = 1'b1;
    repeat (3) tick();
    check("hold3_rst_n", {31'd0, bus.cpu_rst_n}, 32'd0);
    tick();
    check("rel_rst_n", {31'd0, bus.cpu_rst_n}, 32'd1);
    check("rel_state", {29'd0, bus.state}, S_RUN);
    repeat (3) tick();
    check("rel_count3", bus.instr_count, 32'd3);

    // Halt / resume
    for (int i = 0; i < 100 && m_count < 20; i++) tick();
    check("cnt20", bus.instr_count, 32'd20);
    bus.halt_req = 1; tick(); bus.halt_req = 0;
    check("halt_state", {29'd0, bus.state}, S_HALT);
    check("halt_count", bus.instr_count, 32'd21);
    bus.step = 1; repeat (10) tick();
    bus.step = 0; repeat (10) tick();
    check("halt_ign_step", {29'd0, bus.state}, S_HALT);
    check("halt_frozen", bus.instr_count, 32'd21);
    bus.resume = 1; tick(); bus.resume = 0;
    check("resume_run", {29'd0, bus.state}, S_RUN);

    // halt_req beats run_s falling in the same cycle
    bus.run_mode = 0; tick(); tick();
    bus.halt_req = 1; tick(); bus.halt_req = 0;
    check("prio_halt", {29'd0, bus.state}, S_HALT);
    bus.resume = 1; tick(); bus.resume = 0;
    check("resume_pause", {29'd0, bus.state}, S_PAUSE);

    // Step pressed during RUN must not surface once paused
    bus.run_mode = 1; repeat (3) tick();
    check("back_run", {29'd0, bus.state}, S_RUN);
    bus.step = 1; repeat (12) tick();
    bus.step = 0; repeat (12) tick();
    bus.run_mode = 0; repeat (4) tick();
    snap = m_count;
    repeat (5) tick();
    check("run_step_drop", {29'd0, bus.state}, S_PAUSE);
    check("run_step_cnt", bus.instr_count, snap);

    // Bouncy press: exactly one advance
    snap = m_count; en_cyc = 0;
    for (int i = 0; i < 30; i++) begin
      bus.step = (i < 2) || (i >= 4 && i < 14) || (i >= 16 && i < 18);
      tick();
      en_cyc += int'(bus.cpu_en);
    end
    check("step_once", en_cyc, 32'd1);
    check("step_cnt", bus.instr_count, snap + 32'd1);
    check("step_back", {29'd0, bus.state}, S_PAUSE);

    // 3-cycle glitch: no advance
    snap = m_count; en_cyc = 0;
    for (int i = 0; i < 15; i++) begin
      bus.step = (i < 3);
      tick();
      en_cyc += int'(bus.cpu_en);
    end
    check("glitch_none", en_cyc, 32'd0);
    check("glitch_cnt", bus.instr_count, snap);

    // Asynchronous reset while in STEP
    bus.step = 1; found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      tick();
      if (m_state == S_STEP) found = 1;
    end
    check("step_reached", found, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_en",    {31'd0, bus.cpu_en}, 32'd0);
    check("mid_rst_rst_n", {31'd0, bus.cpu_rst_n}, 32'd0);
    check("mid_rst_cnt",   bus.instr_count, 32'd0);
    check("mid_rst_state", {29'd0, bus.state}, S_HOLD);
    model_reset();
    bus.step = 0; tick(); tick();
    rst = 1'b1; bus.run_mode = 1;
    repeat (6) tick();

    // Randomized traffic
    hold_left = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) bus.run_mode = ~bus.run_mode;
      if (hold_left == 0) begin
        bus.step  = 1'($urandom_range(0, 1));
        hold_left = $urandom_range(1, 8);
      end
      hold_left--;
      bus.halt_req = ($urandom_range(0, 15) == 0);
      bus.resume   = ($urandom_range(0, 11) == 0);
      tick();
    end
    bus.halt_req = 0; bus.resume = 0; bus.step = 0; bus.run_mode = 1;
    repeat (3) tick();
    bus.resume = 1; tick(); bus.resume = 0; tick();
    check("pre_bp_run", {29'd0, bus.state}, S_RUN);

    // Breakpoint at BASE+0x10 while free-running from BASE
    bus.pc = BASE; bus.bp_addr = BASE + 32'h10; bus.bp_valid = 1;
    hit_at = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.halted && hit_at < 0) hit_at = i;
    end
`ifdef BREAKPOINT_EN
    check("bp_hit_cycle", hit_at, 32'd5);
    bus.resume = 1; tick(); bus.resume = 0;
    repeat (8) tick();
    check("bp_past_state", {29'd0, bus.state}, S_RUN);
`else
    check("bp_never", hit_at, 32'hFFFF_FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
